hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 8-bit core.
- Generates the stall and flush controls for the PC, the IF/ID register and the ID/EX register. Its id_ex_clear output drives the ID/EX stall and jump-clear inputs, which insert a bubble.
- Detects load-use hazards between the ID and EX stages.
- Sequences a multi-cycle flush after a taken jump.
- Freezes the whole pipe while data memory is busy. Keeps saturating performance counters.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles the front end is flushed after a taken jump (legal range 1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_rs_a  in  3  A-source register of the instruction in ID.
- id_rs_b  in  3  B-source register of the instruction in ID.
- id_use_a  in  1  the ID instruction reads id_rs_a.
- id_use_b  in  1  the ID instruction reads id_rs_b.
- ex_rd  in  3  target register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_reg_write  in  1  the EX instruction writes a register.
- jump_taken  in  1  a jump resolved as taken in EX this cycle.
- mem_busy  in  1  data memory is not ready; the pipe must freeze.
- pc_hold  out  1  PC keeps its value.
- if_id_hold  out  1  IF/ID keeps its contents.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_clear  out  1  ID/EX loads all-zero (bubble).
- global_hold  out  1  every pipeline register keeps its contents.
- state_o  out  2  current FSM state, for debug.
- stall_cnt  out  CNT_W  count of load-use bubbles inserted.
- flush_cnt  out  CNT_W  count of jump-flush cycles.

Behaviour:
- FSM states: RUN=0, FLUSH=1, MEM_WAIT=2. Encoding 3 is illegal and returns to RUN on the next clock.
- Internal flush counter fcnt, 3 bits wide.
- Reset: state=RUN, fcnt=0, stall_cnt=0, flush_cnt=0. All control outputs are combinational, so they are 0 while in RUN with no hazard.
- Control outputs are combinational from state plus inputs, giving zero latency. Counters and state are registered.
- Load-use hazard term lu = ex_mem_read & ex_reg_write & ((id_use_a & id_rs_a==ex_rd) | (id_use_b & id_rs_b==ex_rd)). Register 0 is not special-cased.
- Priority within a cycle: rst > mem_busy > jump_taken > lu.
- mem_busy=1 in any state:
  - global_hold=1, pc_hold=1, if_id_hold=1; if_id_flush=0, id_ex_clear=0.
  - Next state is MEM_WAIT. The state being left is saved as ret_state, with fcnt frozen. If already in MEM_WAIT, ret_state and fcnt are unchanged.
  - No counter increments.
- MEM_WAIT with mem_busy=0:
  - Return to ret_state in that same cycle. Outputs are evaluated as for ret_state with the current inputs.
  - The registered state becomes ret_state, or the result of evaluating ret_state's rules.
- RUN, jump_taken=1:
  - if_id_flush=1, id_ex_clear=1, pc_hold=0; flush_cnt += 1.
  - If FLUSH_CYCLES>1: next state FLUSH, fcnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
  - lu is ignored that cycle and stall_cnt is not incremented.
- RUN, lu=1 (no jump):
  - pc_hold=1, if_id_hold=1, id_ex_clear=1; stall_cnt += 1; stay in RUN.
  - The single bubble suffices because the load then advances past EX.
- FLUSH:
  - if_id_flush=1, id_ex_clear=1; flush_cnt += 1; fcnt -= 1.
  - When fcnt reaches 1 in this cycle, next state is RUN.
  - jump_taken=1 in FLUSH (defensive case) reloads fcnt=FLUSH_CYCLES-1 and stays in FLUSH.
  - lu is suppressed in FLUSH.
- Counters saturate at all-ones and do not wrap.
- pc_hold and if_id_flush are never both 1.
- rst asserted mid-flush or mid-wait forces RUN on the next clock and clears all counters and fcnt.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants (ST_RUN, ST_FLUSH, ST_MEM_WAIT);
  - register-index width REG_W=3;
  - the NOP encoding used by IF/ID.
- One natural sub-module, sat_counter (parameter CNT_W; inputs clk, rst, inc; output count). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
1. Load-use detection. Stimulus: after reset, ex_mem_read=1, ex_reg_write=1, ex_rd=3, id_rs_b=3, id_use_b=1 for one cycle. Required response: pc_hold=1, if_id_hold=1, id_ex_clear=1 in that same cycle; stall_cnt becomes 1 at the next edge; state remains 0.
2. Jump flush with default FLUSH_CYCLES=2. Stimulus: jump_taken=1 for one cycle. Required response: if_id_flush=1 and id_ex_clear=1 for exactly 2 cycles; state sequence 0→1→0; flush_cnt=2.
3. Simultaneous jump and load-use. Stimulus: jump_taken=1 together with the case-1 hazard. Required response: the flush outputs are asserted, pc_hold=0, stall_cnt stays 0, flush_cnt increments.
4. Memory wait during a flush. Stimulus: mem_busy=1 for 3 cycles during FLUSH with fcnt=1. Required response: global_hold=1, flush outputs=0, state_o=2, fcnt frozen. After mem_busy drops, exactly one more flush cycle occurs, then RUN.
5. Saturation. Stimulus: force stall_cnt to 0xFFFE, then apply 3 load-use cycles. Required response: the counter reads 0xFFFF and holds.
6. Reset mid-flush. Stimulus: assert rst in the first FLUSH cycle. Required response: the next clock gives state_o=0, counters=0, and all control outputs 0 with idle inputs.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg: shared constants and types for the 8-bit core pipeline     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipe_pkg;

  localparam int unsigned REG_W   = 3;
  localparam int unsigned INSTR_W = 16;

  // All-zero instruction word loaded into IF/ID on a flush.
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter: event counter that sticks at all-ones instead of wrap   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl: stall/flush/freeze sequencing for the 8-bit pipeline    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs_a,
  input  logic [REG_W-1:0] id_rs_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             jump_taken,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_clear,
  output logic             global_hold,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FCNT_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  state_e     w_eval_state;
  logic [2:0] fcnt_q, fcnt_d;
  logic       w_lu;
  logic       w_stall_inc;
  logic       w_flush_inc;

  assign w_lu = ex_mem_read & ex_reg_write &
                ((id_use_a & (id_rs_a == ex_rd)) | (id_use_b & (id_rs_b == ex_rd)));

  // Leaving MEM_WAIT is zero-latency: the saved state's rules apply this cycle.
  assign w_eval_state = ((state_q == ST_MEM_WAIT) && !mem_busy) ? ret_q : state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    fcnt_d      = fcnt_q;
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_clear = 1'b0;
    global_hold = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;

    if (mem_busy) begin
      global_hold = 1'b1;
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      state_d     = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) begin
        ret_d = (state_q == ST_FLUSH) ? ST_FLUSH : ST_RUN;
      end
    end else begin
      case (w_eval_state)
        ST_RUN: begin
          state_d = ST_RUN;
          if (jump_taken) begin
            if_id_flush = 1'b1;
            id_ex_clear = 1'b1;
            w_flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              fcnt_d  = FCNT_RELOAD;
            end
          end else if (w_lu) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_clear = 1'b1;
            w_stall_inc = 1'b1;
          end
        end
        ST_FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_clear = 1'b1;
          w_flush_inc = 1'b1;
          if (jump_taken) begin
            fcnt_d  = FCNT_RELOAD;
            state_d = ST_FLUSH;
          end else begin
            fcnt_d  = fcnt_q - 3'd1;
            state_d = (fcnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign state_o = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_ctrl: directed self-checking bench for hazard_ctrl         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rs_a, id_rs_b, ex_rd;
  logic        id_use_a, id_use_b, ex_mem_read, ex_reg_write, jump_taken, mem_busy;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_clear, global_hold;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt, flush_cnt;

  // Narrow-counter instance used to reach saturation quickly.
  logic        s_lu;
  logic        s_pc_hold, s_if_id_hold, s_if_id_flush, s_id_ex_clear, s_global_hold;
  logic [1:0]  s_state_o;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs_a      (id_rs_a),
    .id_rs_b      (id_rs_b),
    .id_use_a     (id_use_a),
    .id_use_b     (id_use_b),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .jump_taken   (jump_taken),
    .mem_busy     (mem_busy),
    .pc_hold      (pc_hold),
    .if_id_hold   (if_id_hold),
    .if_id_flush  (if_id_flush),
    .id_ex_clear  (id_ex_clear),
    .global_hold  (global_hold),
    .state_o      (state_o),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .id_rs_a      (3'd0),
    .id_rs_b      (3'd0),
    .id_use_a     (s_lu),
    .id_use_b     (1'b0),
    .ex_rd        (3'd0),
    .ex_mem_read  (1'b1),
    .ex_reg_write (1'b1),
    .jump_taken   (1'b0),
    .mem_busy     (1'b0),
    .pc_hold      (s_pc_hold),
    .if_id_hold   (s_if_id_hold),
    .if_id_flush  (s_if_id_flush),
    .id_ex_clear  (s_id_ex_clear),
    .global_hold  (s_global_hold),
    .state_o      (s_state_o),
    .stall_cnt    (s_stall_cnt),
    .flush_cnt    (s_flush_cnt)
  );

  typedef struct packed {
    logic [2:0] rs_a;
    logic [2:0] rs_b;
    logic       use_a;
    logic       use_b;
    logic [2:0] rd;
    logic       mr;
    logic       rw;
    logic [4:0] exp_ctl;  // {pc_hold, if_id_hold, if_id_flush, id_ex_clear, global_hold}
    logic       exp_inc;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string name, input logic [4:0] exp);
    chk(name, {27'd0, pc_hold, if_id_hold, if_id_flush, id_ex_clear, global_hold}, {27'd0, exp});
  endtask

  task automatic set_idle();
    id_rs_a = 3'd0; id_rs_b = 3'd0; ex_rd = 3'd0;
    id_use_a = 1'b0; id_use_b = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    jump_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 3'd3;
    id_rs_b = 3'd3; id_use_b = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_stall;
    int exp_flush;

    vecs[0] = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 1'b0};
    vecs[1] = '{3'd1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 5'b11010, 1'b1};
    vecs[2] = '{3'd5, 3'd0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 5'b11010, 1'b1};
    vecs[3] = '{3'd5, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 5'b00000, 1'b0};
    vecs[4] = '{3'd5, 3'd0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 5'b00000, 1'b0};
    vecs[5] = '{3'd5, 3'd0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 5'b00000, 1'b0};
    vecs[6] = '{3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 5'b11010, 1'b1};
    vecs[7] = '{3'd2, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 5'b00000, 1'b0};
    vecs[8] = '{3'd3, 3'd4, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 5'b00000, 1'b0};

    rst = 1'b1;
    s_lu = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk_ctl("reset_ctl", 5'b00000);
    chk("reset_state", {30'd0, state_o}, 32'd0);
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    tick();

    // Combinational hazard detection in RUN
    exp_stall = 0;
    for (int i = 0; i < 9; i++) begin
      set_idle();
      id_rs_a = vecs[i].rs_a; id_rs_b = vecs[i].rs_b;
      id_use_a = vecs[i].use_a; id_use_b = vecs[i].use_b;
      ex_rd = vecs[i].rd; ex_mem_read = vecs[i].mr; ex_reg_write = vecs[i].rw;
      @(negedge clk);
      chk_ctl($sformatf("vec%0d_ctl", i), vecs[i].exp_ctl);
      tick();
      if (vecs[i].exp_inc) exp_stall++;
      chk($sformatf("vec%0d_state", i), {30'd0, state_o}, 32'd0);
      chk($sformatf("vec%0d_stall_cnt", i), {16'd0, stall_cnt}, exp_stall);
    end
    set_idle();

    // Jump flush: two flush cycles, 0 -> 1 -> 0
    exp_flush = 0;
    jump_taken = 1'b1;
    @(negedge clk);
    chk_ctl("jump_c0_ctl", 5'b00110);
    tick();
    jump_taken = 1'b0;
    exp_flush++;
    chk("jump_c1_state", {30'd0, state_o}, 32'd1);
    @(negedge clk);
    chk_ctl("jump_c1_ctl", 5'b00110);
    tick();
    exp_flush++;
    chk("jump_c2_state", {30'd0, state_o}, 32'd0);
    @(negedge clk);
    chk_ctl("jump_c2_ctl", 5'b00000);
    chk("jump_flush_cnt", {16'd0, flush_cnt}, exp_flush);

    // Jump together with load-use; hazard stays suppressed in FLUSH
    tick();
    set_lu();
    jump_taken = 1'b1;
    @(negedge clk);
    chk_ctl("jlu_c0_ctl", 5'b00110);
    tick();
    jump_taken = 1'b0;
    exp_flush++;
    chk("jlu_c1_state", {30'd0, state_o}, 32'd1);
    @(negedge clk);
    chk_ctl("jlu_c1_ctl", 5'b00110);
    tick();
    exp_flush++;
    set_idle();
    chk("jlu_stall_cnt", {16'd0, stall_cnt}, exp_stall);
    chk("jlu_flush_cnt", {16'd0, flush_cnt}, exp_flush);
    chk("jlu_end_state", {30'd0, state_o}, 32'd0);

    // Memory wait in the middle of a flush
    jump_taken = 1'b1;
    tick();
    jump_taken = 1'b0;
    exp_flush++;
    mem_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_ctl($sformatf("mw%0d_ctl", c), 5'b11001);
      tick();
      chk($sformatf("mw%0d_state", c), {30'd0, state_o}, 32'd2);
    end
    chk("mw_flush_cnt_frozen", {16'd0, flush_cnt}, exp_flush);
    mem_busy = 1'b0;
    @(negedge clk);
    chk_ctl("mw_resume_ctl", 5'b00110);
    tick();
    exp_flush++;
    chk("mw_resume_state", {30'd0, state_o}, 32'd0);
    @(negedge clk);
    chk_ctl("mw_after_ctl", 5'b00000);
    chk("mw_flush_cnt", {16'd0, flush_cnt}, exp_flush);

    // Reset asserted in the first FLUSH cycle
    tick();
    jump_taken = 1'b1;
    tick();
    jump_taken = 1'b0;
    chk("rstf_in_flush", {30'd0, state_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstf_state", {30'd0, state_o}, 32'd0);
    chk("rstf_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rstf_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk_ctl("rstf_ctl", 5'b00000);

    // Saturation on the 2-bit instance: 1, 2, 3, then holds at 3
    tick();
    s_lu = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("sat%0d_cnt", c), {30'd0, s_stall_cnt}, (c < 3) ? c + 1 : 3);
    end
    s_lu = 1'b0;
    tick();
    chk("sat_hold_cnt", {30'd0, s_stall_cnt}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
